cache_fill_ctrl: RTL and testbench

- Memory-side controller directly downstream of the I-cache and D-cache in the pipelined cpu.
- Arbitrates I-miss, D-miss and D-cache write-through stores onto the single pipelined main memory.
- On a miss, streams a 16-byte block (8 halfwords) into the missing cache, then pulses a done signal so that cache writes its tag and releases its stall.

---
 rtl/cache_fill_ctrl.sv | 138 +++++++++++++
 tb/tb_cache_fill_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// Memory-side fill controller: arbitrates write-through stores and I/D-cache misses onto
// one pipelined memory and streams each missing block back into the requesting cache.
module cache_fill_ctrl #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ic_miss,
    input  logic [ADDR_W-1:0]                  ic_miss_addr,
    input  logic                               dc_miss,
    input  logic [ADDR_W-1:0]                  dc_miss_addr,
    input  logic                               dc_wr_req,
    input  logic [ADDR_W-1:0]                  dc_wr_addr,
    input  logic [DATA_W-1:0]                  dc_wr_data,
    output logic                               dc_wr_ack,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic                               mem_data_valid,
    input  logic [DATA_W-1:0]                  mem_rdata,
    output logic                               ic_fill_we,
    output logic                               dc_fill_we,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               ic_fill_done,
    output logic                               dc_fill_done,
    output logic                               busy
);
    localparam int CW = $clog2(WORDS_PER_BLOCK);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [CW-1:0]     LAST     = CW'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state_q, state_d;
    logic              tgt_dc_q, tgt_dc_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]     iss_q, iss_d;
    logic              iss_end_q, iss_end_d;
    logic [CW-1:0]     rcv_q, rcv_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tgt_dc_q  <= 1'b0;
            base_q    <= '0;
            iss_q     <= '0;
            iss_end_q <= 1'b0;
            rcv_q     <= '0;
        end else begin
            state_q   <= state_d;
            tgt_dc_q  <= tgt_dc_d;
            base_q    <= base_d;
            iss_q     <= iss_d;
            iss_end_q <= iss_end_d;
            rcv_q     <= rcv_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tgt_dc_d     = tgt_dc_q;
        base_d       = base_q;
        iss_d        = iss_q;
        iss_end_d    = iss_end_q;
        rcv_d        = rcv_q;
        dc_wr_ack    = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        ic_fill_we   = 1'b0;
        dc_fill_we   = 1'b0;
        fill_word    = '0;
        fill_data    = '0;
        ic_fill_done = 1'b0;
        dc_fill_done = 1'b0;

        case (state_q)
            IDLE: begin
                iss_d     = '0;
                iss_end_d = 1'b0;
                rcv_d     = '0;
                // A store takes the memory port outright; any pending miss waits a cycle.
                if (dc_wr_req) begin
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = dc_wr_addr;
                    mem_wdata = dc_wr_data;
                    dc_wr_ack = 1'b1;
                end else if (dc_miss) begin
                    tgt_dc_d = 1'b1;
                    base_d   = dc_miss_addr & BLK_MASK;
                    state_d  = FILL;
                end else if (ic_miss) begin
                    tgt_dc_d = 1'b0;
                    base_d   = ic_miss_addr & BLK_MASK;
                    state_d  = FILL;
                end
            end
            FILL: begin
                // iss_end_q stops issue after the last word without letting the counter wrap.
                if (!iss_end_q) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + (ADDR_W'(iss_q) << 1);
                    iss_d    = iss_q + CW'(1);
                    if (iss_q == LAST) begin
                        iss_end_d = 1'b1;
                    end
                end
                if (mem_data_valid) begin
                    ic_fill_we = !tgt_dc_q;
                    dc_fill_we = tgt_dc_q;
                    fill_word  = rcv_q;
                    fill_data  = mem_rdata;
                    rcv_d      = rcv_q + CW'(1);
                    if (rcv_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ic_fill_done = !tgt_dc_q;
                dc_fill_done = tgt_dc_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a 3-cycle-latency memory model and
// scoreboard queues for issued read addresses and cache fill writes.
module tb_cache_fill_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        ic_miss, dc_miss, dc_wr_req;
    logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
    logic        dc_wr_ack, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic        mem_data_valid;
    logic        ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, busy;
    logic [2:0]  fill_word;

    always #5 clk = ~clk;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
        .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .dc_wr_ack(dc_wr_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
        .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
        .fill_word(fill_word), .fill_data(fill_data),
        .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done),
        .busy(busy)
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory model: a read seen in cycle t returns its data during cycle t+3.
    logic        s1v = 1'b0, s2v = 1'b0, s3v = 1'b0;
    logic [15:0] s1a = '0, s2a = '0, s3a = '0;
    always @(posedge clk) begin
        s1v <= mem_en && !mem_wr;
        s1a <= mem_addr;
        s2v <= s1v;
        s2a <= s1a;
        s3v <= s2v;
        s3a <= s2a;
    end
    assign mem_data_valid = s3v;
    assign mem_rdata      = s3v ? memf(s3a) : 16'h0000;

    typedef struct packed {
        logic        d;
        logic [2:0]  w;
        logic [15:0] data;
    } fill_t;

    fill_t       exp_fill[$];
    logic [15:0] exp_rd[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] outs();
        return {5'b0, dc_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
                ic_fill_we, dc_fill_we, fill_word, fill_data,
                ic_fill_done, dc_fill_done, busy};
    endfunction

    function automatic logic [63:0] store_vec(input logic [15:0] a, input logic [15:0] d);
        return {5'b0, 1'b1, 1'b1, 1'b1, a, d, 2'b00, 3'b000, 16'h0000, 3'b000};
    endfunction

    task automatic push_block(input logic d, input logic [15:0] addr);
        logic [15:0] b;
        fill_t       e;
        b = addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            exp_rd.push_back(b + 16'(2 * i));
            e.d    = d;
            e.w    = 3'(i);
            e.data = memf(b + 16'(2 * i));
            exp_fill.push_back(e);
        end
    endtask

    // Called at the negedge of the detect cycle; k is the done cycle relative to it.
    task automatic run_until(input logic d, input int maxc, output int k, output logic [63:0] rdmask);
        k      = -1;
        rdmask = '0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (mem_en && !mem_wr && c < 64) rdmask[c] = 1'b1;
            if (d ? dc_fill_done : ic_fill_done) begin
                k = c;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mem_en && !mem_wr) begin
            if (exp_rd.size() == 0) chk("rd_extra", 64'(exp_rd.size()), 64'd1);
            else chk("rd_addr", {48'b0, mem_addr}, {48'b0, exp_rd.pop_front()});
        end
        if (busy && mem_en) chk("no_wr_busy", {63'b0, mem_wr}, 64'd0);
        if (busy && dc_wr_req) chk("no_ack_busy", {63'b0, dc_wr_ack}, 64'd0);
        if (ic_fill_we || dc_fill_we) begin
            if (exp_fill.size() == 0) begin
                chk("fill_extra", 64'(exp_fill.size()), 64'd1);
            end else begin
                fill_t e;
                e = exp_fill.pop_front();
                chk("fill_we", {43'b0, ic_fill_we, dc_fill_we, fill_word, fill_data},
                    {43'b0, !e.d, e.d, e.w, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          k;
        int          found;
        logic [63:0] m;

        rst = 1'b1;
        ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
        ic_miss_addr = '0; dc_miss_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;

        // Reset and idle
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", outs(), 64'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("idle_outs", outs(), 64'd0);
        end

        // D-miss at 0x1236
        @(posedge clk); #1;
        dc_miss = 1'b1; dc_miss_addr = 16'h1236;
        push_block(1'b1, 16'h1236);
        @(negedge clk);
        chk("dmiss_detect", outs(), 64'd0);
        run_until(1'b1, 40, k, m);
        chk("dmiss_done_lat", 64'(k), 64'd12);
        chk("dmiss_rd_cycles", m, 64'h1FE);
        chk("dmiss_done_outs", outs(), 64'h3);
        dc_miss = 1'b0;

        // Simultaneous I and D miss: D first, then I
        @(posedge clk); #1;
        ic_miss = 1'b1; ic_miss_addr = 16'h0040;
        dc_miss = 1'b1; dc_miss_addr = 16'h2008;
        push_block(1'b1, 16'h2008);
        push_block(1'b0, 16'h0040);
        @(negedge clk);
        chk("both_detect", outs(), 64'd0);
        run_until(1'b1, 40, k, m);
        chk("both_d_done_lat", 64'(k), 64'd12);
        dc_miss = 1'b0;
        run_until(1'b0, 40, k, m);
        chk("both_i_done_lat", 64'(k), 64'd13);
        chk("both_i_rd_cycles", m, 64'h3FC);
        chk("both_i_done_outs", outs(), 64'h5);
        ic_miss = 1'b0;

        // Store arriving during an I-fill waits for IDLE
        @(posedge clk); #1;
        ic_miss = 1'b1; ic_miss_addr = 16'h0106;
        push_block(1'b0, 16'h0106);
        @(negedge clk);
        repeat (3) @(negedge clk);
        dc_wr_req = 1'b1; dc_wr_addr = 16'h3002; dc_wr_data = 16'hBEEF;
        run_until(1'b0, 40, k, m);
        chk("st_fill_done_lat", 64'(k), 64'd9);
        ic_miss = 1'b0;
        @(negedge clk);
        chk("st_after_fill", outs(), store_vec(16'h3002, 16'hBEEF));

        // Store and D-miss together in IDLE
        @(posedge clk); #1;
        dc_wr_addr = 16'h4444; dc_wr_data = 16'h1357;
        dc_miss = 1'b1; dc_miss_addr = 16'h5550;
        push_block(1'b1, 16'h5550);
        @(negedge clk);
        chk("sm_store", outs(), store_vec(16'h4444, 16'h1357));
        @(posedge clk); #1 dc_wr_req = 1'b0;
        @(negedge clk);
        chk("sm_detect", outs(), 64'd0);
        run_until(1'b1, 40, k, m);
        chk("sm_done_lat", 64'(k), 64'd12);
        dc_miss = 1'b0;

        // Reset after the 3rd fill word, then restart of the same block
        @(posedge clk); #1;
        dc_miss = 1'b1; dc_miss_addr = 16'h7A1C;
        push_block(1'b1, 16'h7A1C);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dc_fill_we && fill_word == 3'd2) begin
                found = 1;
                break;
            end
        end
        chk("rst_word2_seen", 64'(found), 64'd1);
        #2 rst = 1'b1;
        #1 chk("rst_async", outs(), 64'd0);
        exp_rd.delete();
        exp_fill.delete();
        repeat (4) begin
            @(negedge clk);
            chk("rst_hold", outs(), 64'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        push_block(1'b1, 16'h7A1C);
        @(negedge clk);
        chk("rst_rel_detect", outs(), 64'd0);
        run_until(1'b1, 40, k, m);
        chk("rst_refill_lat", 64'(k), 64'd12);
        chk("rst_refill_rd", m, 64'h1FE);
        dc_miss = 1'b0;

        @(negedge clk);
        chk("rd_q_empty", 64'(exp_rd.size()), 64'd0);
        chk("fill_q_empty", 64'(exp_fill.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
